branch_predict_queue: RTL
=========================

BRANCH_PREDICT_QUEUE -- requirements
Module: branch_predict_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of in-flight prediction entries (power of two, 2..16).
REQ-002 SHALL have port iCLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port inRESET  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iRESET_SYNC  input  1  synchronous reset, active-high.
REQ-005 SHALL have port iFLUSH  input  1  pipeline flush, active-high; empties the queue.
REQ-006 SHALL have port iPUSH_STB  input  1  fetch records one prediction.
REQ-007 SHALL have port iPUSH_INST_ADDR  input  32  fetched branch instruction address.
REQ-008 SHALL have port iPUSH_PREDICT_TAKEN  input  1  fetch predicted taken (branch cache hit AND predict bit).
REQ-009 SHALL have port iPUSH_PREDICT_ADDR  input  32  predicted target (branch cache search address).
REQ-010 SHALL have port oPUSH_FULL  output  1  queue holds DEPTH entries; fetch must stall.
REQ-011 SHALL have port iRESOLVE_STB  input  1  execute resolves the oldest branch.
REQ-012 SHALL have port iRESOLVE_TAKEN  input  1  actual branch outcome.
REQ-013 SHALL have port iRESOLVE_ADDR  input  32  actual branch target.
REQ-014 SHALL have port oUPD_STB / oUPD_HIT / oUPD_ADDR / oUPD_INST_ADDR  output  1/1/32/32  training write to the branch cache jump port.
REQ-015 SHALL have port oMISPREDICT_STB  output  1  one-cycle redirect pulse.
REQ-016 SHALL have port oMISPREDICT_ADDR  output  32  correct next fetch address.
REQ-017 SHALL have port oRESOLVE_ERROR  output  1  sticky; a resolve arrived while empty.

Function
REQ-018 SHALL store entries {inst_addr, predict_taken, predict_addr} in a circular buffer with read and write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
REQ-019 SHALL accept a push only when count < DEPTH.
  - A push while full is discarded, even if a resolve occurs in the same cycle.
REQ-020 SHALL drive oPUSH_FULL combinationally from the registered count (count == DEPTH).
REQ-021 SHALL, on iRESOLVE_STB with count > 0, pop the head entry and compare it against the actual outcome.
  - Mispredict = (predict_taken != iRESOLVE_TAKEN) OR (both taken AND predict_addr != iRESOLVE_ADDR).
REQ-022 SHALL register the training outputs one cycle after each valid resolve:
  - oUPD_STB = 1
  - oUPD_INST_ADDR = head inst_addr
  - oUPD_ADDR = iRESOLVE_ADDR
  - oUPD_HIT = !iRESOLVE_TAKEN (HIT=0 moves the 2-bit counter toward predict-branch)
REQ-023 SHALL register the redirect outputs one cycle after a mispredicting resolve:
  - oMISPREDICT_STB = 1
  - oMISPREDICT_ADDR = iRESOLVE_ADDR if taken, else inst_addr + 4 (32-bit modulo wrap)
REQ-024 SHALL, on a mispredicting resolve, empty the queue at the same edge (count = 0, pointers equal), discarding any same-cycle push as wrong-path.
REQ-025 SHALL, on a correct resolve with a simultaneous accepted push, leave count unchanged and advance both pointers.
REQ-026 SHALL treat iRESOLVE_STB with count == 0 as an error:
  - no pop and no update
  - set oRESOLVE_ERROR, which holds until reset/flush.
REQ-027 SHALL hold oUPD_STB and oMISPREDICT_STB low in every cycle not following a qualifying resolve; data outputs hold their last values.
REQ-028 SHALL wrap pointers modulo DEPTH with no lost or duplicated entries.

Reset
REQ-029 SHALL, on inRESET low, asynchronously clear count, pointers, oUPD_STB, oUPD_HIT, oMISPREDICT_STB and oRESOLVE_ERROR.
  - oUPD_ADDR, oUPD_INST_ADDR and oMISPREDICT_ADDR reset to 32'h0.
REQ-030 SHALL treat iRESET_SYNC or iFLUSH identically to reset at the next edge, with priority over push and resolve in the same cycle.
REQ-031 SHALL leave entry storage uninitialized; validity is derived solely from count.

Structure
REQ-032 SHALL keep the entry field widths and the DEPTH default in the shared core package.
REQ-033 SHALL be a single module with no sub-modules; the mispredict compare is a local function.

Verification
REQ-034 SHALL show that 4 pushes (DEPTH=4) assert oPUSH_FULL, a 5th push is dropped, and 4 correct resolves return entries in push order.
REQ-035 SHALL show that push {0x100, taken, 0x200} then resolve {taken, 0x200} gives oUPD_STB=1, HIT=0, ADDR=0x200, INST_ADDR=0x100 next cycle, with no mispredict.
REQ-036 SHALL show that push {0x104, taken, 0x300} then resolve {not taken} gives oMISPREDICT_STB=1 with ADDR=0x108, oUPD_HIT=1, and count=0.
REQ-037 SHALL show that a push of {0xFFFFFFFC, not taken} resolved taken to 0x40 gives oMISPREDICT_ADDR=0x40; resolved not-taken after a taken prediction gives 0x00000000 (wrap).
REQ-038 SHALL show that resolve on an empty queue sets oRESOLVE_ERROR with no oUPD_STB, and iFLUSH clears it.
REQ-039 SHALL show that iFLUSH with simultaneous push+resolve gives count=0, no oUPD_STB, and no oMISPREDICT_STB next cycle.

Source files
------------

// File: rtl/branch_predict_queue_pkg.sv
// Shared definitions for the branch prediction queue: entry layout and default depth.
package branch_predict_queue_pkg;

  localparam int BPQ_ADDR_W        = 32;
  localparam int BPQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [BPQ_ADDR_W-1:0] inst_addr;
    logic                  predict_taken;
    logic [BPQ_ADDR_W-1:0] predict_addr;
  } bpq_entry_t;

endpackage

// File: rtl/branch_predict_queue.sv
// In-flight branch prediction FIFO: records fetch predictions, compares them against
// execute outcomes, trains the branch cache and raises a redirect on mispredict.
module branch_predict_queue
  import branch_predict_queue_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH_DEFAULT
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iFLUSH,
  input  logic                  iPUSH_STB,
  input  logic [BPQ_ADDR_W-1:0] iPUSH_INST_ADDR,
  input  logic                  iPUSH_PREDICT_TAKEN,
  input  logic [BPQ_ADDR_W-1:0] iPUSH_PREDICT_ADDR,
  output logic                  oPUSH_FULL,
  input  logic                  iRESOLVE_STB,
  input  logic                  iRESOLVE_TAKEN,
  input  logic [BPQ_ADDR_W-1:0] iRESOLVE_ADDR,
  output logic                  oUPD_STB,
  output logic                  oUPD_HIT,
  output logic [BPQ_ADDR_W-1:0] oUPD_ADDR,
  output logic [BPQ_ADDR_W-1:0] oUPD_INST_ADDR,
  output logic                  oMISPREDICT_STB,
  output logic [BPQ_ADDR_W-1:0] oMISPREDICT_ADDR,
  output logic                  oRESOLVE_ERROR
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  function automatic logic is_mispredict(input bpq_entry_t e, input logic taken,
                                         input logic [BPQ_ADDR_W-1:0] addr);
    return (e.predict_taken != taken) || (e.predict_taken && taken && (e.predict_addr != addr));
  endfunction

  function automatic logic [BPQ_ADDR_W-1:0] redirect_addr(input bpq_entry_t e, input logic taken,
                                                          input logic [BPQ_ADDR_W-1:0] addr);
    return taken ? addr : (e.inst_addr + BPQ_ADDR_W'(4));
  endfunction

  bpq_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  bpq_entry_t            head_p0;
  logic                  clear_p0, push_ok_p0, resolve_ok_p0, mispred_p0;

  logic                  upd_vld_p1, upd_hit_p1, mis_vld_p1, err_p1;
  logic [BPQ_ADDR_W-1:0] upd_addr_p1, upd_inst_addr_p1, mis_addr_p1;

  assign oPUSH_FULL    = (count == FULL_CNT);
  assign head_p0       = mem[rd_ptr];
  assign clear_p0      = iRESET_SYNC | iFLUSH;
  assign push_ok_p0    = iPUSH_STB && !oPUSH_FULL;
  assign resolve_ok_p0 = iRESOLVE_STB && (count != '0);
  assign mispred_p0    = resolve_ok_p0 && is_mispredict(head_p0, iRESOLVE_TAKEN, iRESOLVE_ADDR);

  // Entry storage carries no reset; only count decides which slots are live.
  always_ff @(posedge iCLOCK) begin
    if (push_ok_p0 && !clear_p0 && !mispred_p0) begin
      mem[wr_ptr] <= '{inst_addr:     iPUSH_INST_ADDR,
                       predict_taken: iPUSH_PREDICT_TAKEN,
                       predict_addr:  iPUSH_PREDICT_ADDR};
    end
  end

  // Stage p0 -> p1: queue bookkeeping and registered training/redirect outputs.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      upd_vld_p1       <= 1'b0;
      upd_hit_p1       <= 1'b0;
      upd_addr_p1      <= '0;
      upd_inst_addr_p1 <= '0;
      mis_vld_p1       <= 1'b0;
      mis_addr_p1      <= '0;
      err_p1           <= 1'b0;
    end else if (clear_p0) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      upd_vld_p1       <= 1'b0;
      upd_hit_p1       <= 1'b0;
      upd_addr_p1      <= '0;
      upd_inst_addr_p1 <= '0;
      mis_vld_p1       <= 1'b0;
      mis_addr_p1      <= '0;
      err_p1           <= 1'b0;
    end else begin
      upd_vld_p1 <= resolve_ok_p0;
      mis_vld_p1 <= mispred_p0;
      if (iRESOLVE_STB && (count == '0)) err_p1 <= 1'b1;
      if (resolve_ok_p0) begin
        upd_hit_p1       <= !iRESOLVE_TAKEN;
        upd_addr_p1      <= iRESOLVE_ADDR;
        upd_inst_addr_p1 <= head_p0.inst_addr;
      end
      if (mispred_p0) begin
        mis_addr_p1 <= redirect_addr(head_p0, iRESOLVE_TAKEN, iRESOLVE_ADDR);
        // Everything younger than a mispredicted branch is wrong-path, including a same-cycle push.
        rd_ptr      <= wr_ptr;
        count       <= '0;
      end else begin
        if (push_ok_p0)    wr_ptr <= wr_ptr + 1'b1;
        if (resolve_ok_p0) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok_p0 && !resolve_ok_p0)      count <= count + 1'b1;
        else if (!push_ok_p0 && resolve_ok_p0) count <= count - 1'b1;
      end
    end
  end

  assign oUPD_STB         = upd_vld_p1;
  assign oUPD_HIT         = upd_hit_p1;
  assign oUPD_ADDR        = upd_addr_p1;
  assign oUPD_INST_ADDR   = upd_inst_addr_p1;
  assign oMISPREDICT_STB  = mis_vld_p1;
  assign oMISPREDICT_ADDR = mis_addr_p1;
  assign oRESOLVE_ERROR   = err_p1;

endmodule
